// File: rtl/alu_issue_fifo.sv
// ============================================================================
// alu_issue_fifo : in-order operand buffer feeding the EX-stage ALU
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_fifo #(
  parameter int DEPTH        = 4,
  parameter int ALU_OP_WIDTH = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [ALU_OP_WIDTH-1:0]    in_operator_i,
  input  logic [31:0]                in_operand_a_i,
  input  logic [31:0]                in_operand_b_i,
  input  logic [31:0]                in_operand_c_i,
  input  logic [1:0]                 in_vector_mode_i,
  output logic                       enable_o,
  output logic [ALU_OP_WIDTH-1:0]    operator_o,
  output logic [31:0]                operand_a_o,
  output logic [31:0]                operand_b_o,
  output logic [31:0]                operand_c_o,
  output logic [1:0]                 vector_mode_o,
  input  logic                       alu_ready_i,
  input  logic                       ex_ready_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int c_ptr_w   = $clog2(DEPTH);
  localparam int c_cnt_w   = c_ptr_w + 1;
  localparam int c_entry_w = ALU_OP_WIDTH + 96 + 2;
  localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);

  logic [c_entry_w-1:0] r_mem [DEPTH];
  logic [c_ptr_w-1:0]   r_wp;
  logic [c_ptr_w-1:0]   r_rp;
  logic [c_cnt_w-1:0]   r_count;

  logic                 w_push;
  logic                 w_pop;
  logic [c_entry_w-1:0] w_in_entry;
  logic [c_entry_w-1:0] w_head;

  // in_ready depends on registered occupancy only; a full buffer never
  // accepts in the same cycle it pops.
  assign in_ready_o = (r_count != c_full);
  assign enable_o   = (r_count != '0);
  assign w_push     = in_valid_i && in_ready_o;
  assign w_pop      = enable_o && alu_ready_i && ex_ready_i;

  assign w_in_entry = {in_operator_i, in_operand_a_i, in_operand_b_i,
                       in_operand_c_i, in_vector_mode_i};
  assign w_head     = enable_o ? r_mem[r_rp] : '0;

  assign {operator_o, operand_a_o, operand_b_o, operand_c_o, vector_mode_o} = w_head;
  assign count_o = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush_i) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= w_in_entry;
        r_wp        <= r_wp + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rp <= r_rp + c_ptr_w'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_fifo.sv
// ============================================================================
// tb_alu_issue_fifo : directed self-checking bench for alu_issue_fifo
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_issue_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [6:0]  in_operator_i = '0;
  logic [31:0] in_operand_a_i = '0;
  logic [31:0] in_operand_b_i = '0;
  logic [31:0] in_operand_c_i = '0;
  logic [1:0]  in_vector_mode_i = '0;
  logic        enable_o;
  logic [6:0]  operator_o;
  logic [31:0] operand_a_o;
  logic [31:0] operand_b_o;
  logic [31:0] operand_c_o;
  logic [1:0]  vector_mode_o;
  logic        alu_ready_i = 1'b0;
  logic        ex_ready_i = 1'b0;
  logic [2:0]  count_o;

  int checks = 0;
  int errors = 0;

  alu_issue_fifo #(.DEPTH(4), .ALU_OP_WIDTH(7)) dut (
    .clk              (clk),
    .rst              (rst),
    .flush_i          (flush_i),
    .in_valid_i       (in_valid_i),
    .in_ready_o       (in_ready_o),
    .in_operator_i    (in_operator_i),
    .in_operand_a_i   (in_operand_a_i),
    .in_operand_b_i   (in_operand_b_i),
    .in_operand_c_i   (in_operand_c_i),
    .in_vector_mode_i (in_vector_mode_i),
    .enable_o         (enable_o),
    .operator_o       (operator_o),
    .operand_a_o      (operand_a_o),
    .operand_b_o      (operand_b_o),
    .operand_c_o      (operand_c_o),
    .vector_mode_o    (vector_mode_o),
    .alu_ready_i      (alu_ready_i),
    .ex_ready_i       (ex_ready_i),
    .count_o          (count_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] c, input logic [1:0] vm);
    in_valid_i       = v;
    in_operator_i    = op;
    in_operand_a_i   = a;
    in_operand_b_i   = b;
    in_operand_c_i   = c;
    in_vector_mode_i = vm;
  endtask

  initial begin
    // reset then a single op
    tick();
    check("rst_enable", enable_o, 1'b0);
    check("rst_count", count_o, 3'd0);
    check("rst_in_ready", in_ready_o, 1'b1);
    check("rst_data", {operator_o, operand_a_o, operand_b_o, operand_c_o, vector_mode_o}, '0);
    tick();
    rst = 1'b0;
    drive(1'b1, 7'h18, 32'd5, 32'd7, 32'd0, 2'd0);
    tick();
    drive(1'b0, 7'h00, 32'd0, 32'd0, 32'd0, 2'd0);
    check("single_enable", enable_o, 1'b1);
    check("single_op", operator_o, 7'h18);
    check("single_a", operand_a_o, 32'd5);
    check("single_b", operand_b_o, 32'd7);
    check("single_count", count_o, 3'd1);
    alu_ready_i = 1'b1;
    ex_ready_i  = 1'b1;
    tick();
    check("single_pop_count", count_o, 3'd0);
    check("single_pop_enable", enable_o, 1'b0);
    check("empty_data_zero", operand_a_o, 32'd0);

    // fill, hold-off, drain
    alu_ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 7'h01, 32'(i), 32'd0, 32'd0, 2'd0);
      tick();
    end
    check("full_in_ready", in_ready_o, 1'b0);
    check("full_count", count_o, 3'd4);
    drive(1'b1, 7'h01, 32'd99, 32'd0, 32'd0, 2'd0);
    tick();
    check("holdoff_count", count_o, 3'd4);
    check("holdoff_head", operand_a_o, 32'd1);
    drive(1'b0, 7'h00, 32'd0, 32'd0, 32'd0, 2'd0);
    alu_ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("drain_order", operand_a_o, 32'(i));
      tick();
    end
    check("drain_empty", count_o, 3'd0);

    // wrapped pass; full-with-pop refuses the push, next cycle accepts
    alu_ready_i = 1'b0;
    for (int i = 5; i <= 8; i++) begin
      drive(1'b1, 7'h02, 32'(i), 32'd0, 32'd0, 2'd1);
      tick();
    end
    check("wrap_full", count_o, 3'd4);
    alu_ready_i = 1'b1;
    drive(1'b1, 7'h02, 32'd9, 32'd0, 32'd0, 2'd1);
    check("wrap_head5", operand_a_o, 32'd5);
    tick();
    check("full_pop_count", count_o, 3'd3);
    check("full_pop_in_ready", in_ready_o, 1'b1);
    check("wrap_head6", operand_a_o, 32'd6);
    tick();
    drive(1'b0, 7'h00, 32'd0, 32'd0, 32'd0, 2'd0);
    check("pushpop_count", count_o, 3'd3);
    for (int i = 7; i <= 9; i++) begin
      check("wrap_order", operand_a_o, 32'(i));
      check("wrap_vm", vector_mode_o, 2'd1);
      tick();
    end
    check("wrap_empty", count_o, 3'd0);

    // multi-cycle stall
    alu_ready_i = 1'b0;
    drive(1'b1, 7'h31, 32'd100, 32'd7, 32'd3, 2'd2);
    tick();
    drive(1'b0, 7'h00, 32'd0, 32'd0, 32'd0, 2'd0);
    for (int i = 0; i < 35; i++) begin
      check("stall_head", {operator_o, operand_a_o, operand_b_o, operand_c_o, vector_mode_o},
            {7'h31, 32'd100, 32'd7, 32'd3, 2'd2});
      check("stall_count", count_o, 3'd1);
      tick();
    end
    alu_ready_i = 1'b1;
    tick();
    check("stall_pop", count_o, 3'd0);

    // EX back-pressure
    ex_ready_i = 1'b0;
    drive(1'b1, 7'h03, 32'd11, 32'd12, 32'd0, 2'd0);
    tick();
    drive(1'b0, 7'h00, 32'd0, 32'd0, 32'd0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      check("bp_head", operand_a_o, 32'd11);
      check("bp_count", count_o, 3'd1);
      tick();
    end
    ex_ready_i = 1'b1;
    tick();
    check("bp_pop", count_o, 3'd0);

    // simultaneous push/pop at occupancy 2
    alu_ready_i = 1'b0;
    for (int i = 20; i <= 21; i++) begin
      drive(1'b1, 7'h04, 32'(i), 32'd0, 32'd0, 2'd0);
      tick();
    end
    check("pp_start", count_o, 3'd2);
    alu_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 7'h04, 32'(22 + i), 32'd0, 32'd0, 2'd0);
      check("pp_head", operand_a_o, 32'(20 + i));
      tick();
      check("pp_count", count_o, 3'd2);
    end
    drive(1'b0, 7'h00, 32'd0, 32'd0, 32'd0, 2'd0);
    for (int i = 30; i <= 31; i++) begin
      check("pp_tail", operand_a_o, 32'(i));
      tick();
    end
    check("pp_empty", count_o, 3'd0);

    // flush with concurrent push and pop
    alu_ready_i = 1'b0;
    for (int i = 40; i <= 42; i++) begin
      drive(1'b1, 7'h05, 32'(i), 32'd0, 32'd0, 2'd0);
      tick();
    end
    check("fl_pre_count", count_o, 3'd3);
    alu_ready_i = 1'b1;
    flush_i = 1'b1;
    drive(1'b1, 7'h05, 32'd43, 32'd0, 32'd0, 2'd0);
    tick();
    flush_i = 1'b0;
    drive(1'b0, 7'h00, 32'd0, 32'd0, 32'd0, 2'd0);
    check("fl_count", count_o, 3'd0);
    check("fl_enable", enable_o, 1'b0);
    check("fl_in_ready", in_ready_o, 1'b1);
    check("fl_data", operand_a_o, 32'd0);
    tick();
    check("fl_dropped", enable_o, 1'b0);
    alu_ready_i = 1'b0;
    drive(1'b1, 7'h06, 32'd50, 32'd0, 32'd0, 2'd0);
    tick();
    drive(1'b0, 7'h00, 32'd0, 32'd0, 32'd0, 2'd0);
    check("fl_after_head", operand_a_o, 32'd50);
    check("fl_after_count", count_o, 3'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_issue_fifo.md
# alu_issue_fifo

Operand issue buffer sitting directly upstream of `cv32e40p_alu` in the EX stage. It accepts decoded ALU operations from decode, stores up to DEPTH of them in order, and presents the oldest to the ALU with `enable_o`. It holds operands stable until the ALU reports `ready` and the EX stage reports `ex_ready`. This decouples decode from multi-cycle ALU operations (div/rem) and EX back-pressure.

## Interface

Parameters:
- `DEPTH`, 4, number of entries; power of two, ≥ 2.
- `ALU_OP_WIDTH`, 7, width of the ALU operator field.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `flush_i` in 1: discard all buffered entries.
- `in_valid_i` in 1: decode presents an operation.
- `in_ready_o` out 1: buffer can accept an operation.
- `in_operator_i` in ALU_OP_WIDTH: ALU operator.
- `in_operand_a_i`, `in_operand_b_i`, `in_operand_c_i` in 32 each: operands.
- `in_vector_mode_i` in 2: vector mode.
- `enable_o` out 1: head entry valid; drives ALU `enable_i`.
- `operator_o` out ALU_OP_WIDTH: head operator.
- `operand_a_o`, `operand_b_o`, `operand_c_o` out 32 each: head operands.
- `vector_mode_o` out 2: head vector mode.
- `alu_ready_i` in 1: ALU `ready_o`; low while a multi-cycle operation is in progress.
- `ex_ready_i` in 1: EX stage can retire the result; also fed to the ALU.
- `count_o` out $clog2(DEPTH)+1: number of occupied entries.

## Operation

Storage and pointers:
- Circular buffer of DEPTH entries, each holding {operator, a, b, c, vector_mode}.
- Write pointer `wp` and read pointer `rp`, each $clog2(DEPTH) bits, wrapping naturally modulo DEPTH.
- Occupancy `count`, range 0..DEPTH.

Handshakes:
- Push when `in_valid_i && in_ready_o`: write the entry at `wp`, then increment `wp`.
- `in_ready_o = (count != DEPTH)`. It is registered state only and has no combinational dependency on the pop condition, so a full buffer refuses a push even in a cycle where it pops.
- `enable_o = (count != 0)`.
- Head outputs are the entry at `rp`. All head data outputs are 0 when `count == 0`.
- Pop when `enable_o && alu_ready_i && ex_ready_i`: increment `rp`.
- While `enable_o && !pop`, all head outputs stay bit-stable cycle to cycle. The ALU divider depends on this.

Count update:
- Push only: count+1.
- Pop only: count−1.
- Push and pop in the same cycle: unchanged, both pointers advance.
- Neither: unchanged.

Flush:
- `flush_i` has priority over push and pop in the same cycle.
- Next cycle: `count = 0`, `wp = rp = 0`, `enable_o = 0`, `in_ready_o = 1`.
- A push presented in the flush cycle is dropped.

Reset:
- `rst` is identical to flush and also clears storage to 0.
- Reset values: `in_ready_o = 1`, `enable_o = 0`, all data outputs 0, `count_o = 0`.
- `rst` has priority over `flush_i`.

## Timing

- Push-to-issue latency is 1 cycle: an entry pushed into an empty buffer at edge N appears on the head outputs with `enable_o = 1` after edge N.
- There is no bypass from input to output.
- Back-to-back throughput is 1 operation per cycle when `alu_ready_i` and `ex_ready_i` stay high.
- When full with a pop in cycle N, `in_ready_o` rises after edge N and the next push is accepted in cycle N+1.
- The `alu_ready_i`/`ex_ready_i` inputs are sampled only when `enable_o = 1`; their value while empty has no effect.
- `count_o` reflects registered state. It never exceeds DEPTH and never underflows.

## Test plan

- **Reset then single op.** Assert `rst` for 2 cycles. Push {op=0x18, a=5, b=7, c=0, vm=0}.
  - `enable_o = 0` and `count_o = 0` during reset.
  - `enable_o = 1` with a=5, b=7 exactly one cycle after the push.
  - Pop with both ready signals high → `count_o = 0` after the pop.
- **Fill and wrap.** DEPTH=4. With `alu_ready_i = 0`, push 4 ops (a = 1, 2, 3, 4).
  - `in_ready_o = 0` and `count_o = 4`.
  - A 5th push is held off.
  - Raise ready → ops issue in order 1, 2, 3, 4.
  - Push 4 more (a = 5..8) → they issue in order 5..8, exercising the pointer wrap.
- **Multi-cycle stall.** Head holds a div with a=100, b=7. Hold `alu_ready_i = 0` for 35 cycles.
  - Operands are bit-stable and `count_o` is unchanged across all 35 cycles.
  - Pop occurs on the first cycle with `alu_ready_i = 1` and `ex_ready_i = 1`.
- **EX back-pressure.** `alu_ready_i = 1`, `ex_ready_i = 0` for 3 cycles → no pop, head unchanged. Set `ex_ready_i = 1` → pop in that cycle.
- **Simultaneous push/pop.** `count_o = 2`, continuous push and pop for 10 cycles → `count_o` stays 2 and issue order matches push order.
- **Flush.** With 3 entries, assert `flush_i` in the same cycle as a push and a pop.
  - Next cycle: `count_o = 0`, `enable_o = 0`, `in_ready_o = 1`.
  - The flushed push never appears on the outputs.
